// File: rtl/cpu_datapath_if.sv
// cpu_datapath_if: control, memory and I/O bus between the control FSM, memories and the datapath
interface cpu_datapath_if #(parameter int DATA_W = 8, parameter int ADDR_W = 4);
  localparam int INSTR_W = 2 + 3*ADDR_W;
  logic enmem, enir, enrop1, enrop2, enrio, enpc;
  logic [1:0] seloper, selmux, operacion;
  logic [ADDR_W-1:0] imem_addr, dmem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [DATA_W-1:0] dmem_rdata, dmem_wdata, io_out;
  logic dmem_we, io_valid, flag_c, flag_z;
  modport master (
    output enmem, enir, enrop1, enrop2, enrio, enpc, seloper, selmux, imem_rdata, dmem_rdata,
    input operacion, imem_addr, dmem_addr, dmem_wdata, dmem_we, io_out, io_valid, flag_c, flag_z
  );
  modport slave (
    input enmem, enir, enrop1, enrop2, enrio, enpc, seloper, selmux, imem_rdata, dmem_rdata,
    output operacion, imem_addr, dmem_addr, dmem_wdata, dmem_we, io_out, io_valid, flag_c, flag_z
  );
endinterface

// File: rtl/cpu_datapath.sv
// cpu_datapath: PC, IR, operand/result/IO registers, 2-bit ALU and data-memory address mux
module cpu_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic clk,
  input logic rst_n,
  cpu_datapath_if.slave bus
);
  localparam int INSTR_W = 2 + 3*ADDR_W;
  logic [ADDR_W-1:0] pc, fa, fb, fc;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0] rop1, rop2, racc, rio;
  logic [DATA_W:0] sum, dif, alu;
  logic flag_c, flag_z, io_valid;
  assign fa = ir[3*ADDR_W-1:2*ADDR_W];
  assign fb = ir[2*ADDR_W-1:ADDR_W];
  assign fc = ir[ADDR_W-1:0];
  // operand B comes straight off the data bus, so the result is ready in the OP2 cycle
  assign sum = {1'b0, rop1} + {1'b0, bus.dmem_rdata};
  assign dif = {1'b0, rop1} - {1'b0, bus.dmem_rdata};
  assign alu = bus.seloper == 2'b00 ? sum : bus.seloper == 2'b01 ? dif : {1'b0, rop1};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      ir <= '0;
      rop1 <= '0;
      rop2 <= '0;
      racc <= '0;
      rio <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      io_valid <= 1'b0;
    end else begin
      if (bus.enpc) pc <= pc + 1'b1;
      if (bus.enir) ir <= bus.imem_rdata;
      if (bus.enrop1) rop1 <= bus.dmem_rdata;
      if (bus.enrop2) begin
        rop2 <= bus.dmem_rdata;
        racc <= alu[DATA_W-1:0];
        flag_c <= alu[DATA_W];
        flag_z <= alu[DATA_W-1:0] == '0;
      end
      if (bus.enrio) rio <= bus.dmem_rdata;
      io_valid <= bus.enrio;
    end
  end
  assign bus.operacion = ir[INSTR_W-1:INSTR_W-2];
  assign bus.imem_addr = pc;
  assign bus.dmem_addr = bus.selmux == 2'b00 ? pc : bus.selmux == 2'b01 ? fa : bus.selmux == 2'b10 ? fb : fc;
  assign bus.dmem_wdata = bus.seloper == 2'b10 ? rop1 : racc;
  assign bus.dmem_we = bus.enmem;
  assign bus.io_out = rio;
  assign bus.io_valid = io_valid;
  assign bus.flag_c = flag_c;
  assign bus.flag_z = flag_z;
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed table-driven checks of the datapath driven through FSM-like state sequences
module tb_cpu_datapath;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [13:0] imem [16];
  logic [7:0] dmem [16];
  logic [3:0] exp_pc = '0;
  localparam logic [5:0] C_F = 6'b010001, C_OP1 = 6'b001000, C_OP2 = 6'b000100;
  localparam logic [5:0] C_WC = 6'b100000, C_RIO = 6'b000010, C_PC = 6'b000001, C_NONE = 6'b000000;
  typedef struct {
    logic [1:0] op;
    logic [3:0] a, b, c;
    logic [7:0] va, vb, r;
    logic ec, ez;
  } vec_t;
  vec_t vecs [5];
  cpu_datapath_if bus ();
  cpu_datapath dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_rdata = imem[bus.imem_addr];
  assign bus.dmem_rdata = dmem[bus.dmem_addr];
  always @(posedge clk) if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [5:0] ctl, input logic [1:0] so, input logic [1:0] sm);
    {bus.enmem, bus.enir, bus.enrop1, bus.enrop2, bus.enrio, bus.enpc} = ctl;
    bus.seloper = so;
    bus.selmux = sm;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic step(input logic [5:0] ctl, input logic [1:0] so, input logic [1:0] sm);
    drive(ctl, so, sm);
    tick();
  endtask
  initial begin
    vecs[0] = '{2'b00, 4'd1, 4'd2, 4'd3, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    vecs[1] = '{2'b01, 4'd1, 4'd1, 4'd4, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{2'b01, 4'd8, 4'd9, 4'd10, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[3] = '{2'b00, 4'd11, 4'd12, 4'd13, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
    vecs[4] = '{2'b00, 4'd14, 4'd15, 4'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    for (int i = 0; i < 16; i++) begin
      imem[i] = '0;
      dmem[i] = '0;
    end
    drive(C_NONE, 2'b00, 2'b00);
    #12;
    chk("reset_pc", dut.pc, 0);
    chk("reset_io_valid", bus.io_valid, 0);
    chk("reset_operacion", bus.operacion, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem[exp_pc] = {vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c};
      dmem[vecs[i].a] = vecs[i].va;
      dmem[vecs[i].b] = vecs[i].vb;
      step(C_F, 2'b00, 2'b00);
      exp_pc++;
      chk($sformatf("v%0d_operacion", i), bus.operacion, vecs[i].op);
      step(C_NONE, 2'b00, 2'b00);
      step(C_OP1, 2'b00, 2'b01);
      step(C_OP2, vecs[i].op, 2'b10);
      step(C_WC, 2'b00, 2'b11);
      step(C_NONE, 2'b00, 2'b00);
      chk($sformatf("v%0d_result", i), dmem[vecs[i].c], vecs[i].r);
      chk($sformatf("v%0d_flag_c", i), bus.flag_c, vecs[i].ec);
      chk($sformatf("v%0d_flag_z", i), bus.flag_z, vecs[i].ez);
      chk($sformatf("v%0d_pc", i), bus.imem_addr, exp_pc);
    end
    imem[exp_pc] = {2'b10, 4'd5, 4'd6, 4'd0};
    dmem[5] = 8'hA5;
    dmem[6] = 8'h00;
    step(C_F, 2'b00, 2'b00);
    exp_pc++;
    step(C_NONE, 2'b00, 2'b00);
    step(C_OP1, 2'b10, 2'b01);
    drive(C_WC, 2'b10, 2'b10);
    #1;
    chk("mov_dmem_addr", bus.dmem_addr, 6);
    chk("mov_we", bus.dmem_we, 1);
    chk("mov_wdata", bus.dmem_wdata, 8'hA5);
    tick();
    step(C_NONE, 2'b00, 2'b00);
    chk("mov_result", dmem[6], 8'hA5);
    chk("mov_flag_c", bus.flag_c, 1);
    chk("mov_flag_z", bus.flag_z, 1);
    imem[exp_pc] = {2'b11, 4'd7, 4'd0, 4'd0};
    dmem[7] = 8'h3C;
    step(C_F, 2'b00, 2'b00);
    exp_pc++;
    step(C_NONE, 2'b00, 2'b00);
    chk("out_valid_before", bus.io_valid, 0);
    step(C_RIO, 2'b11, 2'b01);
    chk("out_io_out", bus.io_out, 8'h3C);
    chk("out_valid_pulse", bus.io_valid, 1);
    step(C_NONE, 2'b00, 2'b00);
    chk("out_valid_drop", bus.io_valid, 0);
    chk("out_pc", bus.imem_addr, exp_pc);
    step(C_RIO, 2'b11, 2'b01);
    step(C_RIO, 2'b11, 2'b01);
    chk("b2b_valid", bus.io_valid, 1);
    step(C_NONE, 2'b00, 2'b00);
    chk("b2b_valid_drop", bus.io_valid, 0);
    step(C_OP1 | C_OP2, 2'b00, 2'b01);
    chk("dual_rop1", dut.rop1, 8'h3C);
    chk("dual_rop2", dut.rop2, 8'h3C);
    chk("dual_racc", bus.dmem_wdata, 8'hE1);
    chk("dual_flag_c", bus.flag_c, 0);
    chk("dual_flag_z", bus.flag_z, 0);
    imem[15] = 14'h2ABC;
    while (exp_pc != 4'd15) begin
      step(C_PC, 2'b00, 2'b00);
      exp_pc++;
    end
    chk("pc_at_15", bus.imem_addr, 15);
    step(C_F, 2'b00, 2'b00);
    chk("wrap_pc", bus.imem_addr, 0);
    chk("wrap_ir", dut.ir, 14'h2ABC);
    chk("wrap_operacion", bus.operacion, 2'b10);
    step(C_RIO | C_PC, 2'b00, 2'b01);
    chk("pre_rst_valid", bus.io_valid, 1);
    drive(6'b111111, 2'b01, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", dut.pc, 0);
    chk("arst_ir", dut.ir, 0);
    chk("arst_rop1", dut.rop1, 0);
    chk("arst_rop2", dut.rop2, 0);
    chk("arst_racc", dut.racc, 0);
    chk("arst_io_out", bus.io_out, 0);
    chk("arst_io_valid", bus.io_valid, 0);
    chk("arst_flags", {bus.flag_c, bus.flag_z}, 0);
    chk("arst_operacion", bus.operacion, 0);
    tick();
    chk("rst_priority_pc", bus.imem_addr, 0);
    chk("rst_priority_valid", bus.io_valid, 0);
    rst_n = 1'b1;
    step(C_PC, 2'b00, 2'b00);
    chk("post_rst_pc", bus.imem_addr, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Datapath stage directly downstream of the control FSM. It consumes the FSM's per-state enables and selects, and returns the current opcode to the FSM as `operacion`.
- Holds the program counter, instruction register, two operand registers, result register with flags, and the output (I/O) register. It also contains the 2-bit-opcode ALU and the data-memory address mux.
- Instruction memory and data memory are external and asynchronous-read. This block drives their address, write-data and write-enable lines.

Parameters:
DATA_W, 8, data word width (operands, ALU, memory data, I/O)
ADDR_W, 4, data/instruction address width
INSTR_W, 2+3*ADDR_W, instruction width; derived, not overridable

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
enmem  in  1  data-memory write strobe (FSM WC/WB states)
enir  in  1  load instruction register
enrop1  in  1  load operand-1 register
enrop2  in  1  load operand-2 register and result register
enrio  in  1  load output register
enpc  in  1  increment program counter
seloper  in  2  ALU operation: 00 SUM, 01 RES, 10 MOV, 11 OUT
selmux  in  2  dmem address select: 00 PC, 01 field A, 10 field B, 11 field C
operacion  out  2  opcode = ir[INSTR_W-1:INSTR_W-2], to FSM
imem_addr  out  ADDR_W  = pc
imem_rdata  in  INSTR_W  instruction at imem_addr, combinational
dmem_addr  out  ADDR_W  selmux-selected address
dmem_rdata  in  DATA_W  data at dmem_addr, combinational
dmem_wdata  out  DATA_W  write data
dmem_we  out  1  = enmem
io_out  out  DATA_W  output register contents
io_valid  out  1  one-cycle pulse the cycle after io_out is loaded
flag_c  out  1  carry/borrow of last captured ALU result
flag_z  out  1  zero of last captured ALU result

Behaviour:
- Instruction format, MSB to LSB: opcode[2] | A[ADDR_W] | B[ADDR_W] | C[ADDR_W].
- Reset (rst_n=0, asynchronous, any time including mid-instruction): pc, ir, rop1, rop2, racc, rio, flag_c, flag_z and io_valid all go to 0 immediately.
  - Consequences: operacion=00, imem_addr=0, io_out=0.
  - Reset has priority over every enable. After release, the first rising edge honours the enables.
- PC: on enpc, pc <= pc+1 modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0. It holds otherwise.
- IR: on enir, ir <= imem_rdata, captured at the same edge with zero latency because the read is asynchronous.
- dmem_addr is combinational from selmux and ir: 00 -> pc, 01 -> A, 10 -> B, 11 -> C.
- rop1: on enrop1, rop1 <= dmem_rdata.
- rop2: on enrop2, rop2 <= dmem_rdata.
- ALU is combinational on a=rop1 and b=dmem_rdata (operand B is forwarded from the bus):
  - SUM: {c,r} = a+b, (DATA_W+1)-bit.
  - RES: r = a-b mod 2^DATA_W; c = 1 when a<b (unsigned borrow).
  - MOV and OUT: r = a, c = 0.
  - z = (r==0).
- Result capture: on enrop2, racc <= r, flag_c <= c, flag_z <= z, using the seloper present in that cycle. Flags change only on enrop2.
- dmem_wdata = rop1 when seloper==MOV, otherwise racc. This makes the FSM's WC state (seloper=00) write racc and its WB state (seloper=MOV) write rop1.
- dmem_we = enmem, combinational. The write occurs at the memory on that edge to dmem_addr.
- Output register: on enrio, rio <= dmem_rdata, and io_valid is 1 in the following cycle only. Back-to-back enrio keeps io_valid high in each following cycle.
- Simultaneous enables are legal and independent. Registers load from pre-edge values, so enir together with enpc loads the instruction at the old pc.
- enrop1 and enrop2 in the same cycle: both load the same dmem_rdata, and racc uses the old rop1.
- No enables asserted: all state holds.
- Expected FSM sequences (latency = FSM cycles):
  - SUM/RES: F, D, OP1, OP2, WC, COU = 6 cycles.
  - MOV: F, D, GA, WB, COU = 5 cycles.
  - OUT: F, D, OA, COU = 4 cycles.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with all registers nonzero -> every register and io_valid read 0 before the next clk edge; operacion=00.
- SUM: imem[0]={00,A=1,B=2,C=3}, dmem[1]=0xF0, dmem[2]=0x20, drive F..COU -> dmem[3]=0x10, flag_c=1, flag_z=0, pc=1.
- RES: imem[1]={01,A=1,B=1,C=4}, dmem[1]=0x05 -> dmem[4]=0x00, flag_z=1, flag_c=0; variant a=0x03, b=0x05 -> result 0xFE, flag_c=1.
- MOV: imem={10,A=5,B=6,C=x}, dmem[5]=0xA5 -> dmem[6]=0xA5 written in the WB cycle with dmem_addr=6; flags unchanged.
- OUT: imem={11,A=7,...}, dmem[7]=0x3C -> io_out=0x3C, io_valid high exactly one cycle after the enrio edge.
- PC wrap: pc=15 with ADDR_W=4, pulse enpc -> pc=0 and imem_addr=0; enir+enpc in the same cycle -> ir=imem[15].
